// File: rtl/mv_filter_gate_mc.sv
// Multi-channel trigger-gated moving-average filter: per-channel running sums over a
// runtime-selectable power-of-two window, with the sample history held in one shared RAM.
module mv_filter_gate_mc #(
    parameter int unsigned CH         = 1,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LOG2_WIN   = 12,
    parameter int unsigned DIV_FACTOR = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_trig,
    input  logic [CH*WIDTH-1:0] i_din,
    input  logic [4:0]          i_log2_win,
    input  logic                i_clr,
    output logic [CH*WIDTH-1:0] o_dout,
    output logic                o_valid,
    output logic                o_filled,
    output logic                o_overrun
);

    localparam int unsigned ChW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned DivW  = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
    localparam int unsigned AccW  = WIDTH + LOG2_WIN;
    localparam int unsigned Depth = 2 ** LOG2_WIN;
    localparam int unsigned PtrW  = LOG2_WIN;
    localparam int unsigned FillW = LOG2_WIN + 1;
    localparam int unsigned AddrW = $clog2(CH * Depth);

    typedef enum logic [1:0] {StIdle, StRd, StAcc, StDone} state_e;

    state_e                 state_q, state_d;
    logic [DivW-1:0]        div_q, div_d;
    logic [4:0]             win_q, win_d, win_clamp;
    logic [FillW-1:0]       win_len, fill_q, fill_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr;
    logic [ChW-1:0]         ch_q, ch_d, rdch_q;
    logic [CH*WIDTH-1:0]    hold_q, hold_d, dout_q, dout_d;
    logic [WIDTH-1:0]       new_smp, rdnew_q, rdata_q;
    logic                   rdv_q, valid_q, valid_d, overrun_q, overrun_d;
    logic                   samp_evt, busy, flush, start, fill_full;
    logic [AddrW-1:0]       wr_addr, rd_addr;
    logic signed [AccW-1:0] acc_q [CH];
    logic signed [AccW-1:0] acc_d [CH];
    logic [WIDTH-1:0]       mem [CH*Depth];

    assign win_clamp = (i_log2_win > 5'(LOG2_WIN)) ? 5'(LOG2_WIN) : i_log2_win;
    assign win_len   = FillW'(1) << win_q;
    // A full-depth window subtracts 0 mod depth, i.e. reads the slot about to be overwritten.
    assign rd_ptr    = wr_ptr_q - win_len[PtrW-1:0];
    assign fill_full = (fill_q == win_len);
    assign busy      = (state_q != StIdle);
    assign samp_evt  = i_trig && (div_q == DivW'(DIV_FACTOR - 1));
    // Window changes only take effect between passes; a clear always wins.
    assign flush     = i_clr || (!busy && (win_clamp != win_q));
    assign start     = samp_evt && !busy && !flush;
    assign new_smp   = hold_q[int'(ch_q)*WIDTH +: WIDTH];
    assign wr_addr   = AddrW'({ch_q, wr_ptr_q});
    assign rd_addr   = AddrW'({ch_q, rd_ptr});

    always_comb begin
        div_d = div_q;
        if (flush) begin
            div_d = '0;
        end else if (i_trig) begin
            div_d = samp_evt ? '0 : div_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRd;
                    ch_d    = '0;
                    hold_d  = i_din;
                end
            end
            StRd: begin
                if (ch_q == ChW'(CH - 1)) begin
                    state_d = StAcc;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StAcc:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (i_clr) begin
            state_d = StIdle;
        end
    end

    // Read data for channel rdch_q arrives one cycle after its RD slot.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            acc_d[c] = acc_q[c];
            if (flush) begin
                acc_d[c] = '0;
            end else if (rdv_q && (rdch_q == ChW'(c))) begin
                acc_d[c] = acc_q[c] + {{LOG2_WIN{rdnew_q[WIDTH-1]}}, rdnew_q}
                         - (fill_full ? {{LOG2_WIN{rdata_q[WIDTH-1]}}, rdata_q} : '0);
            end
        end
    end

    always_comb begin
        dout_d    = dout_q;
        valid_d   = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        win_d     = win_q;
        overrun_d = overrun_q;
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            win_d    = win_clamp;
            if (i_clr) begin
                dout_d    = '0;
                overrun_d = 1'b0;
            end
        end else begin
            if (samp_evt && busy) begin
                overrun_d = 1'b1;
            end
            if (state_q == StAcc) begin
                for (int c = 0; c < CH; c++) begin
                    dout_d[c*WIDTH +: WIDTH] = WIDTH'(acc_d[c] >>> win_q);
                end
                valid_d  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (!fill_full) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            win_q     <= '0;
            fill_q    <= '0;
            wr_ptr_q  <= '0;
            ch_q      <= '0;
            rdch_q    <= '0;
            hold_q    <= '0;
            dout_q    <= '0;
            rdnew_q   <= '0;
            rdv_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            wr_ptr_q  <= wr_ptr_d;
            ch_q      <= ch_d;
            rdch_q    <= ch_q;
            hold_q    <= hold_d;
            dout_q    <= dout_d;
            rdnew_q   <= new_smp;
            rdv_q     <= (state_q == StRd) && !i_clr;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    // Read-first RAM; contents are never cleared, the fill counter masks stale entries.
    always_ff @(posedge i_clk) begin
        if (state_q == StRd) begin
            mem[wr_addr] <= new_smp;
        end
        rdata_q <= mem[rd_addr];
    end

    assign o_dout    = dout_q;
    assign o_valid   = valid_q;
    assign o_filled  = fill_full;
    assign o_overrun = overrun_q;

endmodule
